// File: rtl/i2c_txn_scheduler.sv
// ============================================================================
// i2c_txn_scheduler : round-robin I2C transaction scheduler over a byte engine
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_txn_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter int LEN_WIDTH      = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic [NUM_REQ*I2C_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]                req_op_i,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]      req_len_i,
  output logic [NUM_REQ-1:0]                gnt_o,
  input  logic [I2C_DATA_WIDTH-1:0]         wdata_i,
  input  logic                              wdata_valid_i,
  output logic                              wdata_ready_o,
  output logic [I2C_DATA_WIDTH-1:0]         rdata_o,
  output logic                              rdata_valid_o,
  output logic [NUM_REQ-1:0]                done_o,
  output logic [1:0]                        err_o,
  output logic [2:0]                        cmd_o,
  output logic [I2C_DATA_WIDTH-1:0]         cmd_data_o,
  output logic                              cmd_valid_o,
  input  logic                              cmd_ready_i,
  input  logic                              rsp_valid_i,
  input  logic [1:0]                        rsp_i,
  input  logic [I2C_DATA_WIDTH-1:0]         rsp_data_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] CMD_START  = 3'd0;
  localparam logic [2:0] CMD_STOP   = 3'd1;
  localparam logic [2:0] CMD_WRITE  = 3'd2;
  localparam logic [2:0] CMD_RD_ACK = 3'd3;
  localparam logic [2:0] CMD_RD_NAK = 3'd4;
  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_NAK     = 2'd1;
  localparam logic [1:0] ST_ARB     = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_WDATA, S_RDATA, S_STOP, S_DONE
  } state_t;

  // FETCH is only used in S_WDATA: wait for the requester's byte before issuing.
  typedef enum logic [1:0] {PH_ISSUE = 2'd0, PH_WAIT = 2'd1, PH_FETCH = 2'd2} phase_t;

  state_t                    state_q, state_d;
  phase_t                    phase_q, phase_d;
  logic [IDX_W-1:0]          owner_q, owner_d, ptr_q, ptr_d;
  logic [I2C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      op_q, op_d;
  logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
  logic [I2C_DATA_WIDTH-1:0] wbyte_q, wbyte_d, rdata_q, rdata_d;
  logic                      rdata_valid_q, rdata_valid_d;
  logic [1:0]                err_q, err_d;

  logic [I2C_ADDR_WIDTH-1:0] w_addr [NUM_REQ];
  logic [LEN_WIDTH-1:0]      w_len  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr[g] = req_addr_i[g*I2C_ADDR_WIDTH +: I2C_ADDR_WIDTH];
    assign w_len[g]  = req_len_i[g*LEN_WIDTH +: LEN_WIDTH];
  end

  logic             w_found;
  logic [IDX_W-1:0] w_win, w_idx;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  logic [NUM_REQ-1:0] w_owner_oh;
  logic               w_in_txn, w_done, w_last;

  assign w_owner_oh    = NUM_REQ'(1) << owner_q;
  assign w_in_txn      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign w_done        = (state_q == S_DONE);
  assign w_last        = (cnt_q == LEN_WIDTH'(1));
  assign gnt_o         = w_in_txn ? w_owner_oh : '0;
  assign done_o        = w_done ? w_owner_oh : '0;
  assign err_o         = w_done ? err_q : 2'd0;
  assign cmd_valid_o   = w_in_txn && (phase_q == PH_ISSUE);
  assign wdata_ready_o = (state_q == S_WDATA) && (phase_q == PH_FETCH) && wdata_valid_i;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;

  always_comb begin
    cmd_o      = CMD_START;
    cmd_data_o = '0;
    case (state_q)
      S_STOP:  cmd_o = CMD_STOP;
      S_ADDR: begin
        cmd_o      = CMD_WRITE;
        cmd_data_o = I2C_DATA_WIDTH'({addr_q, op_q});
      end
      S_WDATA: begin
        cmd_o      = CMD_WRITE;
        cmd_data_o = wbyte_q;
      end
      S_RDATA: cmd_o = w_last ? CMD_RD_NAK : CMD_RD_ACK;
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    addr_d        = addr_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    wbyte_d       = wbyte_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    err_d         = err_q;
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          state_d = S_START;
          phase_d = PH_ISSUE;
          owner_d = w_win;
          addr_d  = w_addr[w_win];
          op_d    = req_op_i[w_win];
          cnt_d   = w_len[w_win];
          err_d   = ST_OK;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
      end
      default: begin
        case (phase_q)
          PH_ISSUE: if (cmd_ready_i) phase_d = PH_WAIT;
          PH_FETCH: begin
            if (wdata_valid_i) begin
              wbyte_d = wdata_i;
              phase_d = PH_ISSUE;
            end
          end
          default: begin
            if (rsp_valid_i) begin
              phase_d = PH_ISSUE;
              // rsp 2 and 3 both mean the bus is gone; any failure of STOP does too
              if (rsp_i[1] || (state_q == S_STOP && rsp_i != ST_OK)) begin
                state_d = S_DONE;
                err_d   = ST_ARB;
              end else if (rsp_i == ST_NAK) begin
                state_d = S_STOP;
                err_d   = ST_NAK;
              end else begin
                case (state_q)
                  S_START: state_d = S_ADDR;
                  S_ADDR: begin
                    if (cnt_q == '0) begin
                      state_d = S_STOP;
                    end else if (op_q) begin
                      state_d = S_RDATA;
                    end else begin
                      state_d = S_WDATA;
                      phase_d = PH_FETCH;
                    end
                  end
                  S_WDATA: begin
                    cnt_d = cnt_q - 1'b1;
                    if (w_last) state_d = S_STOP;
                    else        phase_d = PH_FETCH;
                  end
                  S_RDATA: begin
                    rdata_d       = rsp_data_i;
                    rdata_valid_d = 1'b1;
                    cnt_d         = cnt_q - 1'b1;
                    if (w_last) state_d = S_STOP;
                  end
                  S_STOP:  state_d = S_DONE;
                  default: ;
                endcase
              end
            end
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= S_IDLE;
      phase_q       <= PH_ISSUE;
      owner_q       <= '0;
      ptr_q         <= '0;
      addr_q        <= '0;
      op_q          <= 1'b0;
      cnt_q         <= '0;
      wbyte_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= ST_OK;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      addr_q        <= addr_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      wbyte_q       <= wbyte_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_txn_scheduler.sv
// ============================================================================
// tb_i2c_txn_scheduler : directed vector bench with a byte-engine model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_i2c_txn_scheduler;

  localparam int NR = 4;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int LW = 4;

  localparam logic [2:0] C_S  = 3'd0;
  localparam logic [2:0] C_P  = 3'd1;
  localparam logic [2:0] C_W  = 3'd2;
  localparam logic [2:0] C_RA = 3'd3;
  localparam logic [2:0] C_RN = 3'd4;
  localparam logic [10:0] Z   = 11'h0;

  logic           clk = 1'b0;
  logic           rst_i = 1'b0;
  logic [NR-1:0]  req_i = '0;
  logic [NR*AW-1:0] req_addr_i = '0;
  logic [NR-1:0]  req_op_i = '0;
  logic [NR*LW-1:0] req_len_i = '0;
  logic [NR-1:0]  gnt_o;
  logic [DW-1:0]  wdata_i = '0;
  logic           wdata_valid_i = 1'b0;
  logic           wdata_ready_o;
  logic [DW-1:0]  rdata_o;
  logic           rdata_valid_o;
  logic [NR-1:0]  done_o;
  logic [1:0]     err_o;
  logic [2:0]     cmd_o;
  logic [DW-1:0]  cmd_data_o;
  logic           cmd_valid_o;
  logic           cmd_ready_i = 1'b1;
  logic           rsp_valid_i = 1'b0;
  logic [1:0]     rsp_i = 2'd0;
  logic [DW-1:0]  rsp_data_i = '0;

  i2c_txn_scheduler #(
    .NUM_REQ(NR), .I2C_ADDR_WIDTH(AW), .I2C_DATA_WIDTH(DW), .LEN_WIDTH(LW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_addr_i(req_addr_i),
    .req_op_i(req_op_i), .req_len_i(req_len_i), .gnt_o(gnt_o),
    .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .done_o(done_o), .err_o(err_o),
    .cmd_o(cmd_o), .cmd_data_o(cmd_data_o), .cmd_valid_o(cmd_valid_o),
    .cmd_ready_i(cmd_ready_i), .rsp_valid_i(rsp_valid_i), .rsp_i(rsp_i),
    .rsp_data_i(rsp_data_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", nm, act, exp);
    end
  endtask

  // Byte-engine model state
  logic [10:0] cmd_log[$];
  logic [7:0]  rd_log[$];
  logic [7:0]  wq[$];
  logic [7:0]  rq[$];
  logic [3:0]  done_order[$];
  int          cmd_idx = 0;
  int          inj_idx = -1;
  logic [1:0]  inj_rsp = 2'd0;
  bit          pend = 1'b0;
  logic [1:0]  pend_rsp = 2'd0;
  logic [7:0]  pend_data = 8'd0;
  int          stall_left = 0;
  int          stalled = 0;
  logic [7:0]  stall_data = 8'd0;
  int          done_cnt = 0;
  logic [3:0]  last_done = '0;
  logic [1:0]  last_err = '0;
  logic [3:0]  gnt_at_done = '0;

  initial begin
    forever begin
      @(negedge clk);
      rsp_valid_i = 1'b0;
      rsp_i       = 2'd0;
      rsp_data_i  = 8'd0;
      if (pend) begin
        rsp_valid_i = 1'b1;
        rsp_i       = pend_rsp;
        rsp_data_i  = pend_data;
        pend        = 1'b0;
      end
      cmd_ready_i = !(stall_left > 0 && cmd_valid_o === 1'b1 && cmd_o === C_W);
      wdata_valid_i = (wq.size() > 0);
      wdata_i       = (wq.size() > 0) ? wq[0] : 8'd0;
      #1;
      if (cmd_valid_o === 1'b1 && cmd_ready_i) begin
        cmd_log.push_back({cmd_o, cmd_data_o});
        pend      = 1'b1;
        pend_rsp  = (cmd_idx == inj_idx) ? inj_rsp : 2'd0;
        pend_data = 8'd0;
        if ((cmd_o == C_RA || cmd_o == C_RN) && rq.size() > 0) pend_data = rq.pop_front();
        cmd_idx++;
      end
      if (cmd_valid_o === 1'b1 && !cmd_ready_i) begin
        stalled++;
        stall_left--;
        check("stall/hold", {21'd0, cmd_o, cmd_data_o}, {21'd0, C_W, stall_data});
      end
      if (wdata_ready_o === 1'b1 && wdata_valid_i) void'(wq.pop_front());
      if (rdata_valid_o === 1'b1) rd_log.push_back(rdata_o);
      if (|done_o) begin
        done_cnt++;
        last_done   = done_o;
        last_err    = err_o;
        gnt_at_done = gnt_o;
        done_order.push_back(done_o);
      end
    end
  end

  typedef struct {
    string            nm;
    int               r;
    bit               op;
    logic [6:0]       a;
    int               len;
    logic [2:0][7:0]  d;
    int               inj_idx;
    logic [1:0]       inj_rsp;
    int               stall;
    logic [1:0]       err;
    int               nrd;
    int               nc;
    logic [5:0][10:0] c;
  } vec_t;

  function automatic logic [10:0] C(input logic [2:0] cmd, input logic [7:0] data);
    return {cmd, data};
  endfunction

  function automatic vec_t mk(input string nm, input int r, input bit op, input logic [6:0] a,
                              input int len, input logic [7:0] d0, d1, d2, input int ii,
                              input logic [1:0] ir, input int st, input logic [1:0] err,
                              input int nrd, input int nc,
                              input logic [10:0] c0, c1, c2, c3, c4, c5);
    vec_t v;
    v.nm = nm; v.r = r; v.op = op; v.a = a; v.len = len; v.d = {d2, d1, d0};
    v.inj_idx = ii; v.inj_rsp = ir; v.stall = st; v.err = err; v.nrd = nrd; v.nc = nc;
    v.c = {c5, c4, c3, c2, c1, c0};
    return v;
  endfunction

  function automatic logic [31:0] all_outs();
    return {gnt_o, done_o, err_o, wdata_ready_o, rdata_valid_o, rdata_o,
            cmd_valid_o, cmd_o, cmd_data_o};
  endfunction

  task automatic run_vec(input vec_t v);
    int         t0;
    logic [3:0] oh;
    logic [10:0] got;
    oh = 4'(1 << v.r);
    cmd_log.delete(); rd_log.delete(); wq.delete(); rq.delete();
    cmd_idx = 0; inj_idx = v.inj_idx; inj_rsp = v.inj_rsp;
    stall_left = v.stall; stalled = 0; stall_data = v.c[1][7:0];
    for (int i = 0; i < v.len && i < 3; i++) begin
      if (v.op) rq.push_back(v.d[i]);
      else      wq.push_back(v.d[i]);
    end
    t0 = done_cnt;
    @(negedge clk);
    req_i = oh;
    req_addr_i[v.r*AW +: AW] = v.a;
    req_op_i[v.r]            = v.op;
    req_len_i[v.r*LW +: LW]  = LW'(v.len);
    @(negedge clk);
    #2;
    check({v.nm, "/grant"}, {24'd0, gnt_o, cmd_valid_o, cmd_o}, {24'd0, oh, 1'b1, C_S});
    // Scramble the request after grant: the transaction must use latched fields.
    req_i      = '0;
    req_addr_i = '1;
    req_op_i   = ~req_op_i;
    req_len_i  = '1;
    for (int c = 0; c < 300 && done_cnt == t0; c++) @(posedge clk);
    check({v.nm, "/done_seen"}, done_cnt - t0, 1);
    repeat (3) @(negedge clk);
    check({v.nm, "/ncmd"}, cmd_log.size(), v.nc);
    for (int i = 0; i < v.nc; i++) begin
      if (i < cmd_log.size()) begin
        got = cmd_log[i];
        if (got[10:8] != C_W) got[7:0] = 8'd0;
        check($sformatf("%s/cmd%0d", v.nm, i), {21'd0, got}, {21'd0, v.c[i]});
      end
    end
    check({v.nm, "/nrd"}, rd_log.size(), v.nrd);
    for (int i = 0; i < v.nrd; i++) begin
      if (i < rd_log.size()) check($sformatf("%s/rd%0d", v.nm, i), {24'd0, rd_log[i]}, {24'd0, v.d[i]});
    end
    check({v.nm, "/done_o"}, {28'd0, last_done}, {28'd0, oh});
    check({v.nm, "/err_o"}, {30'd0, last_err}, {30'd0, v.err});
    check({v.nm, "/gnt_at_done"}, {28'd0, gnt_at_done}, 32'd0);
    check({v.nm, "/stalls"}, stalled, v.stall);
  endtask

  vec_t vecs[8];

  initial begin
    int saved_cmds;
    int t0;
    vecs[0] = mk("wr2", 0, 0, 7'h22, 2, 8'hA5, 8'h5A, 8'h00, -1, 2'd0, 0, 2'd0, 0, 5,
                 C(C_S, 0), C(C_W, 8'h44), C(C_W, 8'hA5), C(C_W, 8'h5A), C(C_P, 0), Z);
    vecs[1] = mk("rd3", 1, 1, 7'h50, 3, 8'h11, 8'h22, 8'h33, -1, 2'd0, 0, 2'd0, 3, 6,
                 C(C_S, 0), C(C_W, 8'hA1), C(C_RA, 0), C(C_RA, 0), C(C_RN, 0), C(C_P, 0));
    vecs[2] = mk("probe", 2, 0, 7'h3C, 0, 8'h00, 8'h00, 8'h00, -1, 2'd0, 0, 2'd0, 0, 3,
                 C(C_S, 0), C(C_W, 8'h78), C(C_P, 0), Z, Z, Z);
    vecs[3] = mk("nak_addr", 3, 0, 7'h10, 2, 8'h01, 8'h02, 8'h00, 1, 2'd1, 0, 2'd1, 0, 3,
                 C(C_S, 0), C(C_W, 8'h20), C(C_P, 0), Z, Z, Z);
    vecs[4] = mk("arb_w2", 0, 0, 7'h33, 2, 8'h01, 8'h02, 8'h00, 3, 2'd2, 0, 2'd2, 0, 4,
                 C(C_S, 0), C(C_W, 8'h66), C(C_W, 8'h01), C(C_W, 8'h02), Z, Z);
    vecs[5] = mk("rsp3", 2, 0, 7'h7F, 1, 8'h99, 8'h00, 8'h00, 0, 2'd3, 0, 2'd2, 0, 1,
                 C(C_S, 0), Z, Z, Z, Z, Z);
    vecs[6] = mk("stall", 3, 0, 7'h01, 1, 8'hC3, 8'h00, 8'h00, -1, 2'd0, 5, 2'd0, 0, 4,
                 C(C_S, 0), C(C_W, 8'h02), C(C_W, 8'hC3), C(C_P, 0), Z, Z);
    vecs[7] = mk("stop_nak", 1, 1, 7'h08, 1, 8'h5C, 8'h00, 8'h00, 3, 2'd1, 0, 2'd2, 1, 4,
                 C(C_S, 0), C(C_W, 8'h11), C(C_RN, 0), C(C_P, 0), Z, Z);

    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("reset/outputs", all_outs(), 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset in the middle of a read: outputs clear at once, no STOP, no done.
    cmd_log.delete(); rd_log.delete(); wq.delete(); rq.delete();
    cmd_idx = 0; inj_idx = -1; stall_left = 0;
    rq.push_back(8'h11); rq.push_back(8'h22); rq.push_back(8'h33);
    @(negedge clk);
    req_i = 4'b0010;
    req_addr_i[1*AW +: AW] = 7'h50;
    req_op_i[1] = 1'b1;
    req_len_i[1*LW +: LW] = 4'd3;
    for (int c = 0; c < 200 && rd_log.size() == 0; c++) @(posedge clk);
    check("rstmid/first_rdata", rd_log.size(), 1);
    @(negedge clk);
    rst_i = 1'b0;
    req_i = '0;
    @(negedge clk);
    #2;
    check("rstmid/outputs", all_outs(), 32'd0);
    pend = 1'b0;
    rq.delete();
    saved_cmds = cmd_log.size();
    t0 = done_cnt;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    repeat (15) @(negedge clk);
    check("rstmid/no_cmds", cmd_log.size(), saved_cmds);
    check("rstmid/no_done", done_cnt - t0, 0);

    // All four requesting: ptr restarts at 0 after reset and rotates.
    for (int i = 0; i < NR; i++) begin
      req_addr_i[i*AW +: AW] = 7'(7'h40 + i);
      req_op_i[i] = 1'b0;
      req_len_i[i*LW +: LW] = '0;
    end
    done_order.delete();
    @(negedge clk);
    req_i = '1;
    for (int c = 0; c < 400 && done_order.size() < 8; c++) @(posedge clk);
    @(negedge clk);
    req_i = '0;
    check("rr/count", (done_order.size() >= 8) ? 8 : done_order.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < done_order.size())
        check($sformatf("rr/order%0d", i), {28'd0, done_order[i]}, {28'd0, 4'(1 << (i % 4))});
    end
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
